// File: rtl/arb_rr4_pkg.sv
// arb_rr4_pkg: shared FSM encoding and default hold limit for the round-robin arbiter
package arb_rr4_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
    localparam int unsigned MAX_HOLD_DEF = 8;
endpackage

// File: rtl/arb_rr4_codpri_rot.sv
// codpri_rot: rotating priority encoder, first set bit of req searched upward from ptr
module codpri_rot (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] y,
    output logic       any
);
    logic [3:0] rot;
    logic [1:0] enc;
    for (genvar i = 0; i < 4; i++) begin : g_rot
        assign rot[i] = req[2'(i) + ptr];
    end
    assign enc = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign y   = enc + ptr;
    assign any = |req;
endmodule

// File: rtl/arb_rr4.sv
// arb_rr4: 4-way round-robin arbiter with grant hold and forced timeout
module arb_rr4
    import arb_rr4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
    parameter int unsigned CW       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);
    state_t        state;
    logic [1:0]    ptr;
    logic [CW-1:0] hold_cnt;
    logic [1:0]    win;
    logic          any;

    codpri_rot u_pri (.req(req), .ptr(ptr), .y(win), .any(any));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= 2'd0;
            hold_cnt  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        state     <= GRANT;
                        gnt       <= 4'b0001 << win;
                        gnt_id    <= win;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= CW'(1);
                    end
                end
                GRANT: begin
                    // release wins over timeout when both happen on the same edge
                    if (!req[gnt_id] || hold_cnt == CW'(MAX_HOLD)) begin
                        state     <= IDLE;
                        gnt       <= 4'b0000;
                        gnt_id    <= 2'd0;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_id + 2'd1;
                        timeout   <= req[gnt_id];
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arb_rr4.sv
// tb_arb_rr4: directed and random checks of arb_rr4 against a behavioural round-robin model
module tb_arb_rr4;
    localparam int MH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    int m_cur  = -1;
    int m_hold = 0;
    int m_ptr  = 0;
    int m_tmo  = 0;

    int order[$];

    arb_rr4 #(.MAX_HOLD(MH), .CW(8)) dut (
        .clock(clock), .reset(reset), .req(req), .gnt(gnt),
        .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".gnt"}, gnt, m_cur < 0 ? 4'b0000 : 4'(1 << m_cur));
        chk({tag, ".gnt_id"}, {2'b00, gnt_id}, m_cur < 0 ? 4'd0 : 4'(m_cur));
        chk({tag, ".gnt_valid"}, {3'b000, gnt_valid}, {3'b000, m_cur >= 0});
        chk({tag, ".timeout"}, {3'b000, timeout}, 4'(m_tmo));
    endtask

    task automatic model_reset();
        m_cur = -1; m_hold = 0; m_ptr = 0; m_tmo = 0;
    endtask

    // one clock: apply r, let the edge sample it, advance the model, compare
    task automatic step(input logic [3:0] r, input string tag);
        req = r;
        @(posedge clock);
        #1;
        m_tmo = 0;
        if (m_cur < 0) begin
            for (int i = 0; i < 4; i++) begin
                if (r[(m_ptr + i) % 4]) begin
                    m_cur = (m_ptr + i) % 4;
                    m_hold = 1;
                    order.push_back(m_cur);
                    break;
                end
            end
        end else if (!r[m_cur]) begin
            m_ptr = (m_cur + 1) % 4;
            m_cur = -1;
        end else if (m_hold == MH) begin
            m_ptr = (m_cur + 1) % 4;
            m_cur = -1;
            m_tmo = 1;
        end else begin
            m_hold++;
        end
        check_all(tag);
    endtask

    task automatic do_reset();
        req = 4'b0000;
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        order.delete();
        check_all("reset");
    endtask

    initial begin
        logic [3:0] r;
        int exp_order[5] = '{0, 1, 2, 3, 0};

        do_reset();
        for (int i = 0; i < 5; i++) step(4'b0000, "idle");

        step(4'b0100, "pre_async");
        step(4'b0100, "pre_async_hold");
        #2;
        reset = 1'b1;
        #1;
        chk("async_gnt", gnt, 4'b0000);
        chk("async_valid", {3'b000, gnt_valid}, 4'd0);
        do_reset();

        for (int i = 0; i < 3; i++) step(4'b0100, "single");
        step(4'b0000, "single_rel");
        step(4'b1001, "single_ptr3");
        step(4'b1001, "single_ptr3_hold");
        chk("single_ptr3_id", {2'b00, gnt_id}, 4'd3);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            r = (m_cur >= 0 && m_hold == 2) ? (4'hF & ~(4'b0001 << m_cur)) : 4'hF;
            step(r, "rotate");
        end
        for (int i = 0; i < 5; i++)
            chk("rotate_order", i < order.size() ? 4'(order[i]) : 4'hF, 4'(exp_order[i]));

        do_reset();
        for (int i = 0; i < 16; i++) step(4'b0011, "timeout2");

        do_reset();
        for (int i = 0; i < 12; i++) step(4'b1000, "hog");
        chk("hog_id", {2'b00, gnt_id}, 4'd3);

        do_reset();
        step(4'b0010, "late_a");
        step(4'b0011, "late_b");
        step(4'b0011, "late_c");
        chk("late_hold", gnt, 4'b0010);
        step(4'b0001, "late_rel");
        step(4'b0001, "late_next");
        chk("late_wrap", gnt, 4'b0001);

        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            step(r, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
